ro_path_spy_array: RTL and testbench
====================================

// Module: ro_path_spy_array
// PURPOSE
//  Multi-channel delay-path spy. Each of NUM_CH channels closes a STAGES-deep NAND/NOT
//  delay path into a gated ring oscillator (RO) and counts its edges for a programmable
//  gate window. A clk-domain FSM sweeps the channels and streams one count per channel.
//  Sits beside the single-path spy chains; counts feed path-delay and trojan analysis.
// PARAMETERS
//  NUM_CH   4   number of RO channels (>=1)
//  STAGES   16  inverting stages per path after the enable NAND; must be even, >=2
//  CNT_W    16  RO edge-counter width
//  GATE_W   16  gate-window length field width (clk cycles)
// PORTS
//  clk           in   1             system clock
//  rst_n         in   1             asynchronous active-low reset
//  start         in   1             sweep request, sampled in IDLE only
//  gate_cycles   in   GATE_W        RO enable window in clk cycles; latched at start
//  ht_in         in   2*NUM_CH      trojan trigger pairs {ht_in2,ht_in1} per channel
//  busy          out  1             high from accepted start until done
//  result_valid  out  1             result available
//  result_ready  in   1             consumer accepts result
//  result_ch     out  clog2(NUM_CH) channel index of result (min width 1)
//  result_count  out  CNT_W         RO rising edges counted in window
//  result_ovf    out  1             RO counter wrapped during window
//  done          out  1             one-cycle pulse after last channel accepted
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all ro_en 0, RO counters cleared.
//  - Ring: NAND(ro_en[c], feedback) + STAGES NAND-with-VCC stages => odd inversion count.
//  - RO counter per channel clocked by ring output; async-cleared by FSM ro_clr; sticky
//    ovf set on carry-out of bit CNT_W-1.
//  - FSM: IDLE -start-> CLEAR; CLEAR (1 cyc, ro_clr=1) -> GATE; GATE (ro_en[ch]=1 for
//    G cycles) -> SETTLE; SETTLE (SETTLE_CYCLES=4, ro_en=0, ring quiescent) -> STORE;
//    STORE (1 cyc, sample count/ovf, result_valid<=1) -> HOLD; HOLD until
//    valid&&ready, then ch==NUM_CH-1 ? DONE : ch++,CLEAR; DONE (done=1, 1 cyc) -> IDLE.
//  - G = gate_cycles latched at start; gate_cycles==0 treated as 1.
//  - Sampling happens only after SETTLE; counter static, no synchroniser required.
//  - result_* stable while result_valid && !result_ready; valid drops the cycle after accept.
//  - start while busy ignored. Latency per channel = 1+G+4+1 cycles + ready wait.
//  - Reset mid-sweep: ro_en drops immediately, counters cleared, no done pulse.
//  - ht_in change mid-window allowed; count reflects mixed behaviour, no error flag.
// CONFIGURATION
//  HT_INSERT_EN defined: per channel, after stage STAGES/2, trig=AND(ht_in1,ht_in2),
//    payload = XOR(stage_out, trig). Inactive: pure extra XOR delay. Active: path
//    inversion parity flips, ring latches, count collapses (<=1).
//  HT_INSERT_EN undefined: payload is a plain buffer (golden path); ht_in unused.
//  All path cells carry keep attributes; sim uses #1 per stage (ignored by synthesis).
// STRUCTURE
//  spy_pkg: FSM state enum, SETTLE_CYCLES=4, CH_W=(NUM_CH>1?clog2(NUM_CH):1) helper.
//  Sub-module ro_spy_chain (one per channel): enable NAND, stages, optional payload,
//    ripple edge counter with async clear and ovf; top holds FSM and result regs.
// TESTING  (clk 10 ns, STAGES=16, 1 ns/stage => period 34 ns golden, 36 ns with XOR)
//  - Reset asserted mid-GATE -> busy=0, result_valid=0, ro_en=0 next edge, no done.
//  - Golden build, gate_cycles=100, ready=1 -> 4 results ch0..3, count 29..30, ovf=0, done.
//  - HT_INSERT_EN, ht_in=0 -> counts 27..28 all channels; ht_in pair ch2=11 -> ch2 <=1.
//  - gate_cycles=0 -> window 1 cycle, count 0..1; CNT_W=4, gate_cycles=100 -> ovf=1.
//  - ready low 20 cycles in HOLD -> result_* constant; start pulsed while busy ignored.
//  - NUM_CH=1 -> single result, result_ch=0, done one cycle after accept.

Source files
------------

// File: rtl/ro_path_spy_array_pkg.sv
// Shared constants for the RO path spy array: FSM encoding, settle length, ring sub-step rate.
// HT_INSERT_EN (chain build option) adds the trojan XOR payload mid-path.
package ro_path_spy_array_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_GATE   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_STORE  = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam int SETTLE_CYCLES = 4;

  // Path stage delays elapsing per clk period (10 ns clk, 1 ns per stage).
  localparam int SUB_STEPS = 10;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ro_path_spy_array_chain.sv
// One spy channel: enable NAND + STAGES inverting cells closed into a ring, plus its edge counter.
// Path advanced SUB_STEPS stage delays per clk; HT_INSERT_EN inserts XOR payload after stage STAGES/2.
module ro_path_spy_array_chain
  import ro_path_spy_array_pkg::*;
#(
  parameter int STAGES = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_en_i,
  input  logic             ro_clr_i,
  input  logic [1:0]       ht_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

`ifdef HT_INSERT_EN
  localparam int XN = 1;
  localparam int PL = STAGES / 2;
  logic trig;
  assign trig = ht_i[0] & ht_i[1];
`else
  localparam int XN = 0;
  logic unused_ht;
  assign unused_ht = ^ht_i;
`endif

  // Node 0 is the enable NAND; the last node feeds back into it.
  localparam int N  = STAGES + 1 + XN;
  localparam int EW = $clog2(SUB_STEPS + 1);

  (* keep = "true" *) logic [N-1:0] node_q;
  logic [N-1:0]     node_d;
  logic [EW-1:0]    edges;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [CNT_W:0]   sum;

  always_comb begin
    logic [N-1:0] cur;
    logic [N-1:0] nxt;
    cur   = node_q;
    nxt   = '0;
    edges = '0;
    for (int k = 0; k < SUB_STEPS; k++) begin
      nxt[0] = ~(ro_en_i & cur[N-1]);
      // Remaining cells are NANDs with one input tied high, i.e. inverters.
      for (int i = 1; i < N; i++) begin
        nxt[i] = ~cur[i-1];
      end
`ifdef HT_INSERT_EN
      nxt[PL+1] = cur[PL] ^ trig;
`endif
      if (!cur[N-1] && nxt[N-1]) begin
        edges = edges + EW'(1);
      end
      cur = nxt;
    end
    node_d = cur;
  end

  assign sum = {1'b0, cnt_q} + (CNT_W+1)'(edges);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      node_q <= node_d;
      if (ro_clr_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= sum[CNT_W-1:0];
        ovf_q <= ovf_q | sum[CNT_W];
      end
    end
  end

  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ro_path_spy_array.sv
// Sweeps NUM_CH ring channels: clear, gate G cycles, settle 4, store, hold result until ready.
// Per channel 1+G+4+1 cycles plus ready wait; result held stable under backpressure. Option: HT_INSERT_EN.
module ro_path_spy_array
  import ro_path_spy_array_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int STAGES = 16,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [GATE_W-1:0]         gate_cycles,
  input  logic [2*NUM_CH-1:0]       ht_in,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ch_w(NUM_CH)-1:0]   result_ch,
  output logic [CNT_W-1:0]          result_count,
  output logic                      result_ovf,
  output logic                      done
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [2:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [GATE_W-1:0] tmr_q, tmr_d;
  logic [NUM_CH-1:0] ro_en_q, ro_en_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              res_ovf_q, res_ovf_d;

  logic              ro_clr;
  logic [CNT_W-1:0]  cnt_w [NUM_CH];
  logic [NUM_CH-1:0] ovf_w;
  logic [CNT_W-1:0]  sel_cnt;
  logic              sel_ovf;

  assign ro_clr = (state_q == ST_CLEAR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ro_path_spy_array_chain #(
      .STAGES (STAGES),
      .CNT_W  (CNT_W)
    ) u_chain (
      .clk      (clk),
      .rst_n    (rst_n),
      .ro_en_i  (ro_en_q[c]),
      .ro_clr_i (ro_clr),
      .ht_i     (ht_in[2*c+1 -: 2]),
      .count_o  (cnt_w[c]),
      .ovf_o    (ovf_w[c])
    );
  end

  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_cnt = cnt_w[c];
        sel_ovf = ovf_w[c];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    gate_d    = gate_q;
    tmr_d     = tmr_q;
    ro_en_d   = ro_en_q;
    vld_d     = vld_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_d  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
          ch_d    = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tmr_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          ro_en_d[c] = (ch_q == CH_W'(c));
        end
        state_d = ST_GATE;
      end
      ST_GATE: begin
        if (tmr_q == gate_q - GATE_W'(1)) begin
          tmr_d   = '0;
          ro_en_d = '0;
          state_d = ST_SETTLE;
        end else begin
          tmr_d = tmr_q + GATE_W'(1);
        end
      end
      // Ring is gated off here; the counter gets time to absorb in-flight edges.
      ST_SETTLE: begin
        if (tmr_q == GATE_W'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_STORE;
        end else begin
          tmr_d = tmr_q + GATE_W'(1);
        end
      end
      ST_STORE: begin
        res_cnt_d = sel_cnt;
        res_ovf_d = sel_ovf;
        vld_d     = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (result_ready) begin
          vld_d = 1'b0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = ST_DONE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_CLEAR;
          end
        end
      end
      ST_DONE: begin
        ch_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        ro_en_d = '0;
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      gate_q    <= '0;
      tmr_q     <= '0;
      ro_en_q   <= '0;
      vld_q     <= 1'b0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gate_q    <= gate_d;
      tmr_q     <= tmr_d;
      ro_en_q   <= ro_en_d;
      vld_q     <= vld_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign result_valid = vld_q;
  assign result_ch    = ch_q;
  assign result_count = res_cnt_q;
  assign result_ovf   = res_ovf_q;

endmodule

// File: tb/tb_ro_path_spy_array.sv
// Directed sweeps with randomized gate lengths, stalls and trigger pairs on a 4-channel array
// and a 1-channel, 4-bit-counter array; counts checked against ring period arithmetic.
module tb_ro_path_spy_array;

`ifdef HT_INSERT_EN
  localparam int XT = 1;
`else
  localparam int XT = 0;
`endif
  localparam int STG       = 16;
  localparam int CLK_NS    = 10;
  localparam int PERIOD_NS = 2 * (STG + 1 + XT);

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_start, a_busy, a_vld, a_rdy, a_ovf, a_done;
  logic [15:0] a_gate, a_cnt;
  logic [7:0]  a_ht;
  logic [1:0]  a_ch;

  logic        b_start, b_busy, b_vld, b_rdy, b_ovf, b_done;
  logic [15:0] b_gate;
  logic [3:0]  b_cnt;
  logic [1:0]  b_ht;
  logic [0:0]  b_ch;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ro_path_spy_array #(.NUM_CH(4), .STAGES(STG), .CNT_W(16), .GATE_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .gate_cycles(a_gate), .ht_in(a_ht),
    .busy(a_busy), .result_valid(a_vld), .result_ready(a_rdy), .result_ch(a_ch),
    .result_count(a_cnt), .result_ovf(a_ovf), .done(a_done)
  );

  ro_path_spy_array #(.NUM_CH(1), .STAGES(STG), .CNT_W(4), .GATE_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .gate_cycles(b_gate), .ht_in(b_ht),
    .busy(b_busy), .result_valid(b_vld), .result_ready(b_rdy), .result_ch(b_ch),
    .result_count(b_cnt), .result_ovf(b_ovf), .done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising ring edges in a window of T ns: floor(T/period), or one more from the edge in flight at gate-off.
  task automatic chk_cnt(input string tag, input logic [15:0] cnt, input logic ovf,
                         input int lo, input int hi, input int cw);
    bit ok;
    int m;
    ok = 1'b0;
    m  = 1 << cw;
    for (int e = lo; e <= hi; e++) begin
      if (cnt === 16'(e % m) && ovf === (e >= m)) ok = 1'b1;
    end
    n_vec++;
    assert (ok) else begin
      n_err++;
      $error("FAIL %s observed count=%0d ovf=%0b expected edges %0d..%0d modulo 2^%0d", tag, cnt, ovf, lo, hi, cw);
    end
  endtask

  task automatic sweep_a(input int gate_in, input int stall_lo, input int stall_hi, input bit poke);
    int g, waited, stall, lo, hi;
    logic       v1;
    logic [7:0] ht;
    logic [19:0] snap;
    bit act;
    g  = (gate_in == 0) ? 1 : gate_in;
    ht = 8'($urandom);
    v1 = 1'b0;
    @(negedge clk);
    a_ht    = ht;
    a_gate  = 16'(gate_in);
    a_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      waited = 0;
      do begin
        @(negedge clk);
        a_start = 1'b0;
        a_rdy   = 1'b0;
        waited++;
        if (waited == 1) v1 = a_vld;
      end while (!a_vld && waited < g + 40);
      if (c > 0) chk("a_vld_drop", v1, 1'b0);
      chk("a_latency", waited, g + 7);
      chk("a_ch", a_ch, c);
      act = (XT == 1) && ht[2*c] && ht[2*c+1];
      lo  = act ? 0 : (g * CLK_NS) / PERIOD_NS;
      hi  = act ? 1 : lo + 1;
      chk_cnt("a_count", a_cnt, a_ovf, lo, hi, 16);
      stall = $urandom_range(stall_hi, stall_lo);
      snap  = {a_ch, a_cnt, a_ovf, a_vld};
      repeat (stall) begin
        @(negedge clk);
        a_start = poke;
      end
      chk("a_hold_stable", {a_ch, a_cnt, a_ovf, a_vld}, snap);
      a_start = 1'b0;
      a_rdy   = 1'b1;
    end
    @(negedge clk);
    a_rdy = 1'b0;
    chk("a_vld_drop_last", a_vld, 1'b0);
    chk("a_done_pulse", a_done, 1'b1);
    @(negedge clk);
    chk("a_done_low", a_done, 1'b0);
    chk("a_busy_low", a_busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("a_idle_after", {a_busy, a_vld}, 2'b00);
  endtask

  task automatic sweep_b(input int gate_in);
    int g, waited, lo;
    g = (gate_in == 0) ? 1 : gate_in;
    @(negedge clk);
    b_ht    = 2'($urandom);
    b_gate  = 16'(gate_in);
    b_start = 1'b1;
    waited  = 0;
    do begin
      @(negedge clk);
      b_start = 1'b0;
      waited++;
    end while (!b_vld && waited < g + 40);
    chk("b_latency", waited, g + 7);
    chk("b_ch", b_ch, 0);
    lo = ((XT == 1) && (b_ht == 2'b11)) ? 0 : (g * CLK_NS) / PERIOD_NS;
    chk_cnt("b_count", {12'd0, b_cnt}, b_ovf, lo, ((XT == 1) && (b_ht == 2'b11)) ? 1 : lo + 1, 4);
    b_rdy = 1'b1;
    @(negedge clk);
    b_rdy = 1'b0;
    chk("b_done_pulse", {b_done, b_vld}, 2'b10);
    @(negedge clk);
    chk("b_done_low", {b_done, b_busy}, 2'b00);
  endtask

  initial begin
    bit seen;
    rst_n   = 1'b0;
    a_start = 1'b0; a_gate = '0; a_ht = '0; a_rdy = 1'b0;
    b_start = 1'b0; b_gate = '0; b_ht = '0; b_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a_outs", {a_busy, a_vld, a_done, a_ovf}, 4'b0000);
    chk("rst_a_data", {a_ch, a_cnt}, 18'd0);
    chk("rst_a_ro_en", dut_a.ro_en_q, 4'b0000);
    chk("rst_b_outs", {b_busy, b_vld, b_done, b_ovf, b_ch, b_cnt}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    sweep_a(100, 1, 3, 1'b0);
    sweep_a(0, 1, 2, 1'b0);
    sweep_a(30, 20, 20, 1'b1);
    repeat (4) sweep_a($urandom_range(120, 1), 1, 4, 1'b0);

    // Reset in the middle of channel 0's gate window.
    @(negedge clk);
    a_gate  = 16'd60;
    a_ht    = '0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("gate_ro_en_live", dut_a.ro_en_q, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {a_busy, a_vld}, 2'b00);
    chk("midrst_ro_en", dut_a.ro_en_q, 4'b0000);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (a_done || a_busy || a_vld) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 1'b0);

    sweep_a(40, 1, 2, 1'b0);
    sweep_b(100);
    sweep_b(5);
    sweep_b($urandom_range(90, 50));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
